bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter (shift/add-3, double-dabble), downstream of the divider.
- Consumes the divider's unsigned integer quotient and produces packed BCD digits plus a significant-digit count for the 7-segment/display driver.
- One bit processed per clock, so area stays small for N=32.
- Start/busy/done handshake on one clock domain.

Parameters:
N, 32, width of binary input
NDIG, 10, number of BCD digits output; must satisfy 10^NDIG > 2^N-1
CW, $clog2(NDIG+1), width of digit-count output (derived, not overridable)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  reset; synchronous, active-high
start_i  input  1  request conversion of bin_i; sampled only when idle
bin_i  input  N  unsigned binary value to convert
busy_o  output  1  conversion in progress; start_i ignored while high
done_o  output  1  single-cycle pulse: bcd_o/ndig_o just updated
bcd_o  output  4*NDIG  packed BCD, digit 0 (units) in [3:0], digit NDIG-1 in MS nibble
ndig_o  output  CW  count of significant digits (1..NDIG); zero reports 1

Behaviour:
- Reset (rst_i=1 at an edge, any state, overrides start_i): state=IDLE, busy_o=0, done_o=0, bcd_o=0, ndig_o=1, internal shift/counter regs=0.
- States: IDLE, SHIFT, FINISH.
- IDLE: at an edge with start_i=1:
  - load shift reg {BCD=0, BIN=bin_i};
  - load bit counter with N;
  - go to SHIFT; busy_o=1 from this edge.
- SHIFT: each edge:
  - every BCD nibble >=5 gets +3 (all nibbles corrected in parallel, combinationally from the current value);
  - then shift the whole {BCD,BIN} left by 1; decrement counter;
  - at the edge where counter goes 1->0, go to FINISH.
  - Exactly N shift edges.
- FINISH: one edge:
  - latch BCD field into bcd_o;
  - compute ndig_o = index of highest non-zero nibble + 1, or 1 if all zero;
  - done_o=1; busy_o=0; return to IDLE.
- Latency: start sampled at edge k; done_o and new bcd_o visible after edge k+N+1 (N=32: 33 cycles); done_o high exactly one cycle.
- Back-to-back: start_i high in the cycle done_o is high is accepted (FSM is already IDLE).
  - Throughput: one conversion per N+1 cycles.
- start_i while busy_o=1: ignored, no queueing; bin_i is not resampled (captured at the start edge only).
- bcd_o/ndig_o hold last result until the next FINISH; they do not change during SHIFT.
- Reset mid-conversion aborts:
  - no done_o pulse;
  - bcd_o cleared to 0 and ndig_o to 1.
- Width rule: BCD field is 4*NDIG bits; with the parameter constraint met no carry leaves the top nibble.
  - The bench asserts that the top nibble never exceeds 9.

Decomposition:
- Package bcd_pkg holds:
  - state enum typedef (IDLE, SHIFT, FINISH), 2-bit;
  - constant function digits_for(n) giving the minimum NDIG;
  - BCD nibble typedef (logic [3:0]).
- Sub-module bcd_add3: 4-bit combinational nibble corrector (in>=5 ? in+3 : in), instantiated NDIG times via generate.
- Top holds FSM, counter, shift register, output registers, leading-digit detector.

Test Plan:
- Reset then start with bin_i=0 -> done_o pulses 33 cycles after start edge; bcd_o=0; ndig_o=1.
- bin_i=1234 -> bcd_o nibbles {..0,1,2,3,4} (low 16 bits 16'h1234, rest 0); ndig_o=4; busy_o high exactly 32 cycles.
- bin_i=32'hFFFF_FFFF -> bcd_o=40'h42_9496_7295; ndig_o=10; top nibble <=9.
- Start with bin_i=1000; pulse start_i with bin_i=7 at cycle 5 while busy -> result 16'h1000, ndig_o=4; only one done_o pulse.
- Back-to-back: start 99 then start 100 in the done_o cycle -> done pulses 33 cycles apart; results 'h99 (ndig 2) then 'h100 (ndig 3).
- Start with bin_i=555, assert rst_i at cycle 10 -> no done_o; bcd_o=0; ndig_o=1; busy_o=0 next cycle; new start then converts correctly.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StShift  = 2'd1,
        StFinish = 2'd2
    } state_e;

    typedef logic [3:0] nibble_t;

    // Digits in 2^n (floor(n*log10(2))+1) also covers 2^n-1 for n>=1.
    function automatic int unsigned digits_for(input int unsigned n);
        return (n * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble corrector: values of 5 or more get +3 before the shift.
module bcd_add3
    import bcd_pkg::*;
(
    input  nibble_t nib_i,
    output nibble_t nib_o
);

    assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock, with start/busy/done handshake
// and a significant-digit count for the display driver.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter  int unsigned N    = 32,
    parameter  int unsigned NDIG = 10,
    localparam int unsigned CW   = $clog2(NDIG + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [N-1:0]      bin_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [4*NDIG-1:0] bcd_o,
    output logic [CW-1:0]     ndig_o
);

    localparam int unsigned BW   = 4 * NDIG;
    localparam int unsigned SW   = BW + N;
    localparam int unsigned CNTW = $clog2(N + 1);

    state_e          state_q, state_d;
    logic [SW-1:0]   sr_q, sr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic [CW-1:0]   ndig_q, ndig_d;
    logic            done_q, done_d;

    logic [BW-1:0]   bcd_adj;
    logic [CW-1:0]   lead;

    for (genvar g = 0; g < NDIG; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nib_i (sr_q[N+4*g +: 4]),
            .nib_o (bcd_adj[4*g +: 4])
        );
    end

    // Highest non-zero nibble wins; an all-zero value still shows one digit.
    always_comb begin
        lead = CW'(1);
        for (int i = 0; i < NDIG; i++) begin
            if (sr_q[N+4*i +: 4] != 4'd0) begin
                lead = CW'(i + 1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        ndig_d  = ndig_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    sr_d    = {{BW{1'b0}}, bin_i};
                    cnt_d   = CNTW'(N);
                    state_d = StShift;
                end
            end
            StShift: begin
                sr_d  = {bcd_adj, sr_q[N-1:0]} << 1;
                cnt_d = cnt_q - CNTW'(1);
                if (cnt_q == CNTW'(1)) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                bcd_d   = sr_q[SW-1:N];
                ndig_d  = lead;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            sr_q    <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            ndig_q  <= CW'(1);
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            ndig_q  <= ndig_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q == StShift);
    assign done_o = done_q;
    assign bcd_o  = bcd_q;
    assign ndig_o = ndig_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: decimal reference model, decoupled done_o monitor.
module tb_bin2bcd_seq;

    localparam int unsigned N    = 32;
    localparam int unsigned NDIG = 10;
    localparam int unsigned CW   = $clog2(NDIG + 1);
    localparam int unsigned BW   = 4 * NDIG;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [N-1:0]  bin_i = '0;
    logic          busy_o;
    logic          done_o;
    logic [BW-1:0] bcd_o;
    logic [CW-1:0] ndig_o;

    bin2bcd_seq #(
        .N    (N),
        .NDIG (NDIG)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .start_i (start_i),
        .bin_i   (bin_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .bcd_o   (bcd_o),
        .ndig_o  (ndig_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] bcd;
        logic [CW-1:0] ndig;
        longint        start_edge;
    } exp_t;

    exp_t          sb_q[$];
    int            n_checks = 0;
    int            n_pass = 0;
    longint        cyc = 0;
    logic [BW-1:0] last_bcd = '0;
    logic [CW-1:0] last_ndig = CW'(1);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: repeated division by ten, digit count from the decimal length.
    function automatic exp_t model(input logic [N-1:0] v);
        exp_t          r;
        longint unsigned t;
        logic [BW-1:0] b;
        int            k;
        b = '0;
        t = longint'(v);
        for (int d = 0; d < int'(NDIG); d++) begin
            b[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
        k = 0;
        t = longint'(v);
        while (t > 0) begin
            k++;
            t = t / 10;
        end
        r.bcd        = b;
        r.ndig       = (k == 0) ? CW'(1) : CW'(k);
        r.start_edge = 0;
        return r;
    endfunction

    // Monitor: every done_o pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_i && done_o) begin
            chk("done_expected", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("bcd", 64'(bcd_o), 64'(e.bcd));
                chk("ndig", 64'(ndig_o), 64'(e.ndig));
                chk("latency", 64'(cyc), 64'(e.start_edge + N + 1));
                chk("top_nibble_le9", 64'(bcd_o[BW-1 -: 4] <= 4'd9), 64'd1);
                last_bcd  = e.bcd;
                last_ndig = e.ndig;
            end
        end
    end

    // Called at a negedge; the following posedge samples start_i.
    task automatic issue(input logic [N-1:0] v);
        exp_t e;
        e            = model(v);
        e.start_edge = cyc + 1;
        sb_q.push_back(e);
        start_i = 1'b1;
        bin_i   = v;
        @(negedge clk);
        start_i = 1'b0;
        bin_i   = $urandom;
    endtask

    task automatic wait_done(output int busy_cnt, input bit chk_hold);
        bit seen;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 0; i < 3 * int'(N); i++) begin
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            if (busy_o) busy_cnt++;
            if (chk_hold && i == int'(N) / 2)
                chk("hold_during_shift", 64'({bcd_o, ndig_o}), 64'({last_bcd, last_ndig}));
            @(negedge clk);
        end
        if (!seen) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run(input logic [N-1:0] v);
        int bc;
        issue(v);
        wait_done(bc, 1'b1);
        chk("busy_cycles", 64'(bc), 64'(N));
    endtask

    initial begin
        int            bc;
        logic [N-1:0]  edge_vals[6];
        edge_vals = '{32'd9, 32'd10, 32'd999_999_999, 32'd1_000_000_000, 32'd65535, 32'd4_000_000_000};

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_bcd", 64'(bcd_o), 64'd0);
        chk("rst_ndig", 64'(ndig_o), 64'd1);
        rst_i = 1'b0;
        @(negedge clk);

        run(32'd0);
        run(32'd1234);
        run(32'hFFFF_FFFF);

        // start_i while busy must be ignored; the monitor flags any extra done_o.
        issue(32'd1000);
        repeat (4) @(negedge clk);
        start_i = 1'b1;
        bin_i   = 32'd7;
        @(negedge clk);
        start_i = 1'b0;
        wait_done(bc, 1'b0);
        repeat (40) @(negedge clk);

        // Back-to-back: second start issued in the done_o cycle.
        issue(32'd99);
        wait_done(bc, 1'b1);
        chk("busy_cycles_b2b0", 64'(bc), 64'(N));
        issue(32'd100);
        wait_done(bc, 1'b1);
        chk("busy_cycles_b2b1", 64'(bc), 64'(N));
        @(negedge clk);

        // Reset mid-conversion.
        issue(32'd555);
        repeat (9) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("abort_busy", 64'(busy_o), 64'd0);
        chk("abort_done", 64'(done_o), 64'd0);
        chk("abort_bcd", 64'(bcd_o), 64'd0);
        chk("abort_ndig", 64'(ndig_o), 64'd1);
        sb_q.delete();
        last_bcd  = '0;
        last_ndig = CW'(1);
        repeat (40) @(negedge clk);
        run(32'd555);

        foreach (edge_vals[i]) run(edge_vals[i]);

        repeat (25) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run(N'($urandom >> $urandom_range(0, 31)));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
